dff_reg: RTL and testbench
==========================

// Module: dff_reg
// PURPOSE
//   Parametrised multi-bit register built on the single-bit flip-flop model: WIDTH D-type
//   bits with synchronous clear, parallel load and increment (74HC161-style).
//   Serves as the CPU's A/B general registers, output port and program counter.
//   Ripple carry out supports cascading and jump-on-carry logic.
// PARAMETERS
//   WIDTH    4     register width in bits (>=1)
//   RST_VAL  '0    value forced onto dout while n_rst is low (WIDTH bits)
// PORTS
//   clk    in   1      rising-edge clock
//   n_rst  in   1      asynchronous active-low reset
//   clr    in   1      synchronous clear (highest sync priority)
//   ld     in   1      synchronous parallel load of din
//   inc    in   1      synchronous increment by 1
//   din    in   WIDTH  parallel load data
//   dout   out  WIDTH  register contents
//   co     out  1      ripple carry out, combinational
//   sh     in   1      shift-left enable (present only with DFF_REG_SHIFT_EN)
//   sin    in   1      serial data into bit 0 (present only with DFF_REG_SHIFT_EN)
// BEHAVIOUR
//   - Reset: n_rst low -> dout = RST_VAL immediately, with no clock edge needed.
//     Held while low; sync inputs ignored. co follows its equation from dout.
//   - First update is on the first rising clk edge after n_rst returns high.
//   - Reset mid-operation: an in-progress load/count is abandoned with no partial state.
//   - Sync priority per rising edge: clr > ld > [sh] > inc > hold.
//       clr: dout <= 0 (not RST_VAL)
//       ld : dout <= din
//       inc: dout <= dout + 1, modulo 2^WIDTH; all-ones wraps to 0, carry discarded
//       none asserted: dout holds
//   - Simultaneous controls resolve strictly by priority.
//     e.g. ld&inc -> din is loaded without increment; clr&ld -> 0.
//   - Latency: one clock; new dout is visible after the edge that samples the controls.
//   - co = inc & ~clr & ~ld & (dout == all ones).
//     Meaning: asserted in the cycle whose edge will wrap the counter.
//     Purely combinational from current dout and controls; deasserted during reset
//     unless RST_VAL is all ones and inc=1.
//   - WIDTH=1: inc toggles the bit; co = inc & ~clr & ~ld & dout.
//   - X/Z on an unselected control input must not corrupt dout.
// CONFIGURATION
//   DFF_REG_SHIFT_EN defined:
//     - Ports sh/sin exist.
//     - sh (below ld, above inc): dout <= {dout[WIDTH-2:0], sin}.
//     - WIDTH=1: dout <= sin.
//     - co additionally gated by ~sh.
//   DFF_REG_SHIFT_EN undefined:
//     - Ports sh/sin do not exist.
//     - Behaviour exactly as above, with no shift path in the logic.
// TESTING (WIDTH=4, RST_VAL=4'h0 unless stated; 10 ns clock)
//   1. n_rst=0 for 50 ns with ld=1, din=4'hA -> dout=4'h0 throughout.
//      Release, ld=1 -> dout=4'hA after next edge.
//   2. Load 4'hE, inc=1 for 3 edges -> dout 4'hF, 4'h0, 4'h1.
//      co=1 only while dout=4'hF.
//   3. Load 4'h5, then ld=1, inc=1, din=4'h9 -> dout=4'h9.
//      Then clr=1, ld=1 -> dout=4'h0.
//   4. dout=4'h7, inc=1, drop n_rst between edges -> dout=4'h0 immediately, before
//      the next edge; stays 0 while low. Repeat with RST_VAL=4'h3 -> dout=4'h3.
//   5. Hold: all controls 0, din toggling for 10 edges -> dout unchanged, co=0.
//   6. DFF_REG_SHIFT_EN: dout=4'h1, sh=1, sin=1 for 2 edges -> 4'h3, 4'h7.
//      sh&inc -> shift only. ld&sh -> load.

Source files
------------

// File: rtl/dff_reg.sv
// WIDTH-bit register with async reset to RST_VAL, sync clear, load and increment.
// Define DFF_REG_SHIFT_EN to add the sh/sin shift-left path (priority below ld, above inc).
module dff_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
`ifdef DFF_REG_SHIFT_EN
  input  logic             sh,
  input  logic             sin,
`endif
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             co
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_all_ones;
  logic             w_cnt_sel;

`ifdef DFF_REG_SHIFT_EN
  logic [WIDTH-1:0] w_shift;

  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign w_shift = sin;
    end else begin : g_shift_wn
      assign w_shift = {r_q[WIDTH-2:0], sin};
    end
  endgenerate

  assign w_cnt_sel = inc & ~clr & ~ld & ~sh;
`else
  assign w_cnt_sel = inc & ~clr & ~ld;
`endif

  // Strict priority chain: a higher-priority control masks X on any lower one.
  always_comb begin
    w_next = r_q;
    if (clr) begin
      w_next = '0;
    end else if (ld) begin
      w_next = din;
`ifdef DFF_REG_SHIFT_EN
    end else if (sh) begin
      w_next = w_shift;
`endif
    end else if (inc) begin
      w_next = r_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_next;
    end
  end

  assign w_all_ones = &r_q;
  assign co         = w_cnt_sel & w_all_ones;
  assign dout       = r_q;

endmodule

// File: tb/tb_dff_reg.sv
// Scoreboard bench for dff_reg: two instances (RST_VAL 0 and 3) driven in lockstep.
// Shift cases run only when DFF_REG_SHIFT_EN is defined.
module tb_dff_reg;

  logic       clk;
  logic       n_rst;
  logic       clr, ld, inc, sh, sin;
  logic [3:0] din;
  logic [3:0] dout, dout3;
  logic       co, co3;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_q, m_q3;

  dff_reg #(.WIDTH(4), .RST_VAL(4'h0)) u_dut (
    .clk(clk), .n_rst(n_rst), .clr(clr), .ld(ld), .inc(inc),
`ifdef DFF_REG_SHIFT_EN
    .sh(sh), .sin(sin),
`endif
    .din(din), .dout(dout), .co(co)
  );

  dff_reg #(.WIDTH(4), .RST_VAL(4'h3)) u_dut3 (
    .clk(clk), .n_rst(n_rst), .clr(clr), .ld(ld), .inc(inc),
`ifdef DFF_REG_SHIFT_EN
    .sh(sh), .sin(sin),
`endif
    .din(din), .dout(dout3), .co(co3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] q, input logic c, l, n,
                                            input logic [3:0] d, input logic s, si);
    if (c)      return 4'h0;
    else if (l) return d;
`ifdef DFF_REG_SHIFT_EN
    else if (s) return {q[2:0], si};
`endif
    else if (n) return q + 4'h1;
    return q;
  endfunction

  function automatic logic model_co(input logic [3:0] q, input logic c, l, n, s);
`ifdef DFF_REG_SHIFT_EN
    return n & ~c & ~l & ~s & (q == 4'hF);
`else
    return n & ~c & ~l & (q == 4'hF);
`endif
  endfunction

  // Drive at negedge, check co combinationally, push expectation, pop after the edge.
  task automatic step(input logic c, l, n, input logic [3:0] d, input logic s, si);
    exp_t e;
    @(negedge clk);
    clr = c; ld = l; inc = n; din = d; sh = s; sin = si;
    #1;
    chk("co", {3'b0, co}, {3'b0, model_co(m_q, c, l, n, s)});
    chk("co3", {3'b0, co3}, {3'b0, model_co(m_q3, c, l, n, s)});
    m_q  = model_next(m_q, c, l, n, d, s, si);
    m_q3 = model_next(m_q3, c, l, n, d, s, si);
    exp_q.push_back('{a: m_q, b: m_q3});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("dout", dout, e.a);
    chk("dout3", dout3, e.b);
  endtask

  initial begin
    n_rst = 1'b0; clr = 1'b0; ld = 1'b1; inc = 1'b0; sh = 1'b0; sin = 1'b0; din = 4'hA;
    m_q = 4'h0; m_q3 = 4'h3;

    // Reset held 50 ns with ld active: no load may occur.
    for (int i = 0; i < 5; i++) begin
      #9;
      chk("rst_dout", dout, 4'h0);
      chk("rst_dout3", dout3, 4'h3);
      chk("rst_co", {3'b0, co}, 4'h0);
      #1;
    end
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("rel_noedge", dout, 4'h0);
    @(posedge clk);
    #1;
    chk("rel_load", dout, 4'hA);
    chk("rel_load3", dout3, 4'hA);
    m_q = 4'hA; m_q3 = 4'hA;

    // Load then count through wrap.
    step(0, 1, 0, 4'hE, 0, 0);
    step(0, 0, 1, 4'h0, 0, 0);
    step(0, 0, 1, 4'h0, 0, 0);
    step(0, 0, 1, 4'h0, 0, 0);

    // Priority cases.
    step(0, 1, 0, 4'h5, 0, 0);
    step(0, 1, 1, 4'h9, 0, 0);
    step(1, 1, 0, 4'h6, 0, 0);
    step(0, 1, 0, 4'hF, 0, 0);
    step(0, 1, 1, 4'h2, 0, 0);
    step(0, 1, 0, 4'hF, 0, 0);
    step(1, 0, 1, 4'h0, 0, 0);

    // X on unselected controls.
    step(0, 1, 0, 4'hB, 0, 0);
    step(1, 1'bx, 1'bx, 4'h4, 0, 0);
    step(0, 1, 1'bx, 4'hC, 0, 0);

    // Async reset mid-count.
    step(0, 1, 0, 4'h7, 0, 0);
    @(negedge clk);
    clr = 1'b0; ld = 1'b0; inc = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_dout", dout, 4'h0);
    chk("arst_dout3", dout3, 4'h3);
    chk("arst_co", {3'b0, co}, 4'h0);
    @(posedge clk);
    #1;
    chk("arst_hold", dout, 4'h0);
    chk("arst_hold3", dout3, 4'h3);
    m_q = 4'h0; m_q3 = 4'h3;
    @(negedge clk);
    n_rst = 1'b1; inc = 1'b0;
    step(0, 0, 1, 4'h0, 0, 0);

    // Hold with din toggling.
    step(0, 1, 0, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 4'($urandom_range(0, 15)), 0, 0);
    end

`ifdef DFF_REG_SHIFT_EN
    step(0, 1, 0, 4'h1, 0, 0);
    step(0, 0, 0, 4'h0, 1, 1);
    step(0, 0, 0, 4'h0, 1, 1);
    step(0, 0, 1, 4'h0, 1, 0);
    step(0, 1, 0, 4'h5, 1, 1);
    step(0, 1, 0, 4'hF, 0, 0);
    step(0, 0, 1, 4'h0, 1, 0);
`endif

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
